// File: rtl/program_loader_pkg.sv
// Shared definitions for the byte-stream program loader: command codes and FSM states.
package program_loader_pkg;

    localparam logic [7:0] CMD_IMEM  = 8'h01;
    localparam logic [7:0] CMD_DMEM  = 8'h02;
    localparam logic [7:0] CMD_START = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_CNT  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles little-endian words, writes them into instruction or
// data memory, and raises a sticky CPU start once the host sends the START command.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic               dmem_we_o,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [31:0]        wdata_o,
    output logic               start_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [15:0]        words_o
);

    localparam int AW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;

    state_t             r_state;
    logic               r_is_dmem;
    logic [AW-1:0]      r_addr;
    logic [8:0]         r_cnt;
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_shift;
    logic [31:0]        r_wdata;
    logic               r_imem_we;
    logic               r_dmem_we;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [DMEM_AW-1:0] r_dmem_addr;
    logic               r_start;
    logic               r_err;
    logic [15:0]        r_words;

    logic               w_accept;
    logic               w_word_done;
    logic [AW-1:0]      w_addr_byte;

    // Once the CPU is started the link is closed until reset.
    assign w_accept    = in_valid_i & ~r_start;
    assign w_word_done = (r_state == ST_DATA) && w_accept && (r_byte_idx == 2'd3);
    assign w_addr_byte = AW'(in_data_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_is_dmem   <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_byte_idx  <= '0;
            r_shift     <= '0;
            r_wdata     <= '0;
            r_imem_we   <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_imem_addr <= '0;
            r_dmem_addr <= '0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= '0;
        end else begin
            r_imem_we <= 1'b0;
            r_dmem_we <= 1'b0;

            if (w_word_done && (r_words != 16'hFFFF)) begin
                r_words <= r_words + 16'd1;
            end

            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        case (in_data_i)
                            CMD_IMEM: begin
                                r_is_dmem <= 1'b0;
                                r_state   <= ST_ADDR;
                            end
                            CMD_DMEM: begin
                                r_is_dmem <= 1'b1;
                                r_state   <= ST_ADDR;
                            end
                            CMD_START: r_start <= 1'b1;
                            default:   r_err   <= 1'b1;
                        endcase
                    end
                    ST_ADDR: begin
                        r_addr  <= w_addr_byte;
                        r_state <= ST_CNT;
                    end
                    ST_CNT: begin
                        // A count byte of zero encodes the maximum of 256 words.
                        r_cnt      <= (in_data_i == 8'd0) ? 9'd256 : {1'b0, in_data_i};
                        r_byte_idx <= 2'd0;
                        r_state    <= ST_DATA;
                    end
                    ST_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_shift    <= {in_data_i, r_shift[23:8]};
                        if (r_byte_idx == 2'd3) begin
                            r_wdata     <= {in_data_i, r_shift};
                            r_imem_addr <= r_addr[IMEM_AW-1:0];
                            r_dmem_addr <= r_addr[DMEM_AW-1:0];
                            r_imem_we   <= ~r_is_dmem;
                            r_dmem_we   <= r_is_dmem;
                            r_addr      <= r_addr + AW'(1);
                            r_cnt       <= r_cnt - 9'd1;
                            if (r_cnt == 9'd1) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_ready_o  = ~r_start;
    assign imem_we_o   = r_imem_we;
    assign imem_addr_o = r_imem_addr;
    assign dmem_we_o   = r_dmem_we;
    assign dmem_addr_o = r_dmem_addr;
    assign wdata_o     = r_wdata;
    assign start_o     = r_start;
    assign busy_o      = (r_state != ST_IDLE);
    assign err_o       = r_err;
    assign words_o     = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: logs every memory write seen on the bus and compares
// against hand-computed addresses, data and counters.
module tb_program_loader;

    localparam int IMEM_AW = 8;
    localparam int DMEM_AW = 5;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [7:0]         in_data_i = 8'h00;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic               imem_we_o;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic               dmem_we_o;
    logic [DMEM_AW-1:0] dmem_addr_o;
    logic [31:0]        wdata_o;
    logic               start_o;
    logic               busy_o;
    logic               err_o;
    logic [15:0]        words_o;

    program_loader #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_addr_o (dmem_addr_o),
        .wdata_o     (wdata_o),
        .start_o     (start_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .words_o     (words_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t  imem_log[$];
    wr_t  dmem_log[$];
    logic both_we_seen = 1'b0;

    // Bus monitor: one log entry per cycle with a write strobe high.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (imem_we_o) imem_log.push_back('{int'(imem_addr_o), wdata_o});
            if (dmem_we_o) dmem_log.push_back('{int'(dmem_addr_o), wdata_o});
            if (imem_we_o && dmem_we_o) both_we_seen = 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    function automatic logic [31:0] ilog_addr(input int i);
        return (i < imem_log.size()) ? 32'(imem_log[i].addr) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] ilog_data(input int i);
        return (i < imem_log.size()) ? imem_log[i].data : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] dlog_addr(input int i);
        return (i < dmem_log.size()) ? 32'(dmem_log[i].addr) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] dlog_data(input int i);
        return (i < dmem_log.size()) ? dmem_log[i].data : 32'hDEAD_BEEF;
    endfunction

    // All stimulus runs at posedge+1 so DUT outputs are settled when sampled.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid_i = 1'b0;
                @(posedge clk_i); #1;
            end
        end
        in_valid_i = 1'b1;
        in_data_i  = b;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    logic [7:0] test1_bytes [11] = '{8'h01, 8'h00, 8'h02,
                                     8'h13, 8'h00, 8'h50, 8'h00,
                                     8'h33, 8'h05, 8'hB5, 8'h00};

    task automatic send_test1(input bit gaps);
        for (int i = 0; i < 11; i++) send_byte(test1_bytes[i], gaps);
    endtask

    int ib;
    int db;

    initial begin
        // Reset state
        rst_i = 1'b1;
        idle_cycles(3);
        rst_i = 1'b0;
        check("reset_ready", 32'(in_ready_o), 32'd1);
        check("reset_start", 32'(start_o),    32'd0);
        check("reset_busy",  32'(busy_o),     32'd0);
        check("reset_err",   32'(err_o),      32'd0);
        check("reset_words", 32'(words_o),    32'd0);
        check("reset_we",    32'({imem_we_o, dmem_we_o}), 32'd0);

        // Test 1: two IMEM words, with exact write-latency check on the first word
        ib = imem_log.size();
        send_byte(8'h01, 1'b0);
        check("t1_busy_after_cmd", 32'(busy_o), 32'd1);
        for (int i = 1; i < 6; i++) send_byte(test1_bytes[i], 1'b0);
        check("t1_no_early_we", 32'(imem_we_o), 32'd0);
        send_byte(test1_bytes[6], 1'b0);
        check("t1_we_next_cycle", 32'(imem_we_o),   32'd1);
        check("t1_we_addr",       32'(imem_addr_o), 32'd0);
        check("t1_we_wdata",      wdata_o,          32'h0050_0013);
        check("t1_dmem_we_low",   32'(dmem_we_o),   32'd0);
        for (int i = 7; i < 11; i++) send_byte(test1_bytes[i], 1'b0);
        idle_cycles(2);
        check("t1_nwrites", 32'(imem_log.size() - ib), 32'd2);
        check("t1_addr0",   ilog_addr(ib),     32'd0);
        check("t1_data0",   ilog_data(ib),     32'h0050_0013);
        check("t1_addr1",   ilog_addr(ib + 1), 32'd1);
        check("t1_data1",   ilog_data(ib + 1), 32'h00B5_0533);
        check("t1_words",   32'(words_o),      32'd2);
        check("t1_busy_end", 32'(busy_o),      32'd0);

        // Test 2: DMEM address wraps 31 -> 0
        ib = imem_log.size();
        db = dmem_log.size();
        send_byte(8'h02, 1'b0); send_byte(8'h1F, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h05, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h06, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        idle_cycles(2);
        check("t2_nwrites", 32'(dmem_log.size() - db), 32'd2);
        check("t2_addr0",   dlog_addr(db),     32'd31);
        check("t2_data0",   dlog_data(db),     32'd5);
        check("t2_addr1",   dlog_addr(db + 1), 32'd0);
        check("t2_data1",   dlog_data(db + 1), 32'd6);
        check("t2_no_imem", 32'(imem_log.size() - ib), 32'd0);
        check("t2_words",   32'(words_o),      32'd4);

        // Test 3: test 1 with random valid gaps
        ib = imem_log.size();
        send_test1(1'b1);
        idle_cycles(2);
        check("t3_nwrites", 32'(imem_log.size() - ib), 32'd2);
        check("t3_addr0",   ilog_addr(ib),     32'd0);
        check("t3_data0",   ilog_data(ib),     32'h0050_0013);
        check("t3_addr1",   ilog_addr(ib + 1), 32'd1);
        check("t3_data1",   ilog_data(ib + 1), 32'h00B5_0533);
        check("t3_words",   32'(words_o),      32'd6);

        // Test 4: bad command, then a valid frame still loads
        send_byte(8'h7E, 1'b0);
        check("t4_err",  32'(err_o),  32'd1);
        check("t4_busy", 32'(busy_o), 32'd0);
        ib = imem_log.size();
        send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0); send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0);
        idle_cycles(2);
        check("t4_nwrites",   32'(imem_log.size() - ib), 32'd1);
        check("t4_addr",      ilog_addr(ib), 32'h10);
        check("t4_data",      ilog_data(ib), 32'hEFBE_ADDE);
        check("t4_err_stuck", 32'(err_o),    32'd1);
        check("t4_words",     32'(words_o),  32'd7);

        // CNT=0 means 256 words; DMEM address wraps every 32 words
        db = dmem_log.size();
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 1'b0); send_byte(8'h00, 1'b0);
            send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        end
        idle_cycles(2);
        check("cnt0_nwrites",  32'(dmem_log.size() - db), 32'd256);
        check("cnt0_addr32",   dlog_addr(db + 32),  32'd0);
        check("cnt0_data32",   dlog_data(db + 32),  32'd32);
        check("cnt0_addr255",  dlog_addr(db + 255), 32'd31);
        check("cnt0_data255",  dlog_data(db + 255), 32'd255);
        check("cnt0_busy_end", 32'(busy_o),         32'd0);
        check("cnt0_words",    32'(words_o),        32'd263);

        // Test 5: reset mid-frame discards the partial word
        ib = imem_log.size();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        rst_i = 1'b1;
        idle_cycles(1);
        rst_i = 1'b0;
        idle_cycles(1);
        check("t5_no_partial", 32'(imem_log.size() - ib), 32'd0);
        check("t5_words_clr",  32'(words_o), 32'd0);
        check("t5_err_clr",    32'(err_o),   32'd0);
        check("t5_busy_clr",   32'(busy_o),  32'd0);
        send_test1(1'b0);
        idle_cycles(2);
        check("t5_nwrites", 32'(imem_log.size() - ib), 32'd2);
        check("t5_data0",   ilog_data(ib),     32'h0050_0013);
        check("t5_addr1",   ilog_addr(ib + 1), 32'd1);
        check("t5_data1",   ilog_data(ib + 1), 32'h00B5_0533);
        check("t5_words",   32'(words_o),      32'd2);

        // Test 6: START closes the link
        send_byte(8'h03, 1'b0);
        check("t6_start", 32'(start_o),    32'd1);
        check("t6_ready", 32'(in_ready_o), 32'd0);
        ib = imem_log.size();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        idle_cycles(2);
        check("t6_ignored",      32'(imem_log.size() - ib), 32'd0);
        check("t6_words",        32'(words_o),    32'd2);
        check("t6_busy",         32'(busy_o),     32'd0);
        check("t6_start_sticky", 32'(start_o),    32'd1);
        check("t6_ready_low",    32'(in_ready_o), 32'd0);

        check("never_both_we", 32'(both_we_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
